// File: rtl/n2_instr_queue_if.sv
// Fetch-side, memory-side and decode-side signals of the n2 instruction queue.
// The queue takes the slave modport; the surrounding fetch/memory/decode logic takes the master.
interface n2_instr_queue_if;
    logic        flush_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic [2:0]  iq_prefetch_ptr_i;
    logic [2:0]  iq_rd_ptr_o;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_ready_i;
    logic        protocol_err_o;

    modport master (
        output flush_i, instr_req_i, instr_addr_i, instr_gnt_i,
        output instr_rvalid_i, instr_rdata_i, iq_prefetch_ptr_i, dec_ready_i,
        input  iq_rd_ptr_o, dec_valid_o, dec_instr_o, dec_pc_o, protocol_err_o
    );

    modport slave (
        input  flush_i, instr_req_i, instr_addr_i, instr_gnt_i,
        input  instr_rvalid_i, instr_rdata_i, iq_prefetch_ptr_i, dec_ready_i,
        output iq_rd_ptr_o, dec_valid_o, dec_instr_o, dec_pc_o, protocol_err_o
    );
endinterface

// File: rtl/n2_instr_queue.sv
// 4-entry in-order instruction queue between fetch and decode: records granted PCs,
// captures in-order memory responses, and drops stale in-flight responses after a flush.
module n2_instr_queue #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] PROGADDR_RESET  = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    n2_instr_queue_if.slave iq
);
    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUTSTANDING);

    logic [31:0] pc_r [4];
    logic [31:0] pc_s [4];
    logic [31:0] instr_r [4];
    logic [31:0] instr_s [4];
    logic [3:0]  pending_r, pending_s;
    logic [3:0]  filled_r, filled_s;
    logic [2:0]  rd_ptr_r, rd_ptr_s;
    logic [2:0]  fill_ptr_r, fill_ptr_s;
    logic [2:0]  outstanding_r, outstanding_s;
    logic [2:0]  drop_cnt_r, drop_cnt_s;
    logic        protocol_err_r, protocol_err_s;

    logic        acc_s;
    logic        rsp_ok_s;
    logic        rsp_err_s;
    logic        pop_s;
    logic        dec_valid_s;
    logic [1:0]  rd_idx_s;
    logic [1:0]  fill_idx_s;
    logic [1:0]  alloc_idx_s;

    assign acc_s       = iq.instr_req_i & iq.instr_gnt_i;
    assign rsp_ok_s    = iq.instr_rvalid_i & (outstanding_r != 3'd0);
    assign rsp_err_s   = iq.instr_rvalid_i & (outstanding_r == 3'd0);
    assign rd_idx_s    = rd_ptr_r[1:0];
    assign fill_idx_s  = fill_ptr_r[1:0];
    assign alloc_idx_s = iq.iq_prefetch_ptr_i[1:0];
    assign dec_valid_s = filled_r[rd_idx_s] & ~iq.flush_i;
    assign pop_s       = dec_valid_s & iq.dec_ready_i;

    assign iq.dec_valid_o    = dec_valid_s;
    assign iq.dec_instr_o    = instr_r[rd_idx_s];
    assign iq.dec_pc_o       = pc_r[rd_idx_s];
    assign iq.iq_rd_ptr_o    = rd_ptr_r;
    assign iq.protocol_err_o = protocol_err_r;

    // Outstanding request count: grant adds one, a legitimate response removes one.
    always_comb begin
        outstanding_s = outstanding_r;
        case ({acc_s, rsp_ok_s})
            2'b10: begin
                if (outstanding_r < MAX_OUT_C) begin
                    outstanding_s = outstanding_r + 3'd1;
                end else begin
                    outstanding_s = outstanding_r;
                end
            end
            2'b01:   outstanding_s = outstanding_r - 3'd1;
            default: outstanding_s = outstanding_r;
        endcase
    end

    // Entry, pointer and drop-count next state; flush outranks pop and fill.
    always_comb begin
        pc_s           = pc_r;
        instr_s        = instr_r;
        pending_s      = pending_r;
        filled_s       = filled_r;
        rd_ptr_s       = rd_ptr_r;
        fill_ptr_s     = fill_ptr_r;
        drop_cnt_s     = drop_cnt_r;
        protocol_err_s = protocol_err_r | rsp_err_s;

        if (iq.flush_i) begin
            pending_s  = 4'b0000;
            filled_s   = 4'b0000;
            rd_ptr_s   = iq.iq_prefetch_ptr_i;
            fill_ptr_s = iq.iq_prefetch_ptr_i;
            // Everything still in flight is stale, including a response landing this cycle.
            if (rsp_ok_s) begin
                drop_cnt_s = outstanding_r - 3'd1;
            end else begin
                drop_cnt_s = outstanding_r;
            end
        end else begin
            if (pop_s) begin
                filled_s[rd_idx_s] = 1'b0;
                rd_ptr_s           = rd_ptr_r + 3'd1;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            if (rsp_ok_s && (drop_cnt_r != 3'd0)) begin
                drop_cnt_s = drop_cnt_r - 3'd1;
            end else if (rsp_ok_s) begin
                instr_s[fill_idx_s]   = iq.instr_rdata_i;
                filled_s[fill_idx_s]  = 1'b1;
                pending_s[fill_idx_s] = 1'b0;
                fill_ptr_s            = fill_ptr_r + 3'd1;
            end else begin
                drop_cnt_s = drop_cnt_r;
            end
        end

        // The redirect fetch granted alongside a flush still owns its slot.
        if (acc_s) begin
            pc_s[alloc_idx_s]      = iq.instr_addr_i;
            pending_s[alloc_idx_s] = 1'b1;
            filled_s[alloc_idx_s]  = 1'b0;
        end else begin
            pending_s = pending_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pc_r[i]    <= PROGADDR_RESET;
                instr_r[i] <= 32'h0000_0000;
            end
            pending_r      <= 4'b0000;
            filled_r       <= 4'b0000;
            rd_ptr_r       <= 3'd0;
            fill_ptr_r     <= 3'd0;
            outstanding_r  <= 3'd0;
            drop_cnt_r     <= 3'd0;
            protocol_err_r <= 1'b0;
        end else begin
            pc_r           <= pc_s;
            instr_r        <= instr_s;
            pending_r      <= pending_s;
            filled_r       <= filled_s;
            rd_ptr_r       <= rd_ptr_s;
            fill_ptr_r     <= fill_ptr_s;
            outstanding_r  <= outstanding_s;
            drop_cnt_r     <= drop_cnt_s;
            protocol_err_r <= protocol_err_s;
        end
    end
endmodule

// File: tb/tb_n2_instr_queue.sv
// Directed self-checking bench for n2_instr_queue; the bench plays the fetch unit,
// memory and decode, and compares queue outputs against hand-computed values.
module tb_n2_instr_queue;
    localparam logic [31:0] PC_RST = 32'h0000_1000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    n2_instr_queue_if iq ();

    n2_instr_queue #(
        .MAX_OUTSTANDING(4),
        .PROGADDR_RESET (PC_RST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .iq (iq.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic req, input logic [31:0] addr, input logic gnt,
                         input logic rv, input logic [31:0] rdata, input logic rdy,
                         input logic fl, input logic [2:0] pfp);
        iq.instr_req_i       = req;
        iq.instr_addr_i      = addr;
        iq.instr_gnt_i       = gnt;
        iq.instr_rvalid_i    = rv;
        iq.instr_rdata_i     = rdata;
        iq.dec_ready_i       = rdy;
        iq.flush_i           = fl;
        iq.iq_prefetch_ptr_i = pfp;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", iq.dec_valid_o); end
        checks++; if (iq.dec_pc_o !== PC_RST) begin errors++; $display("FAIL rst_pc got=%h exp=%h", iq.dec_pc_o, PC_RST); end
        checks++; if (iq.dec_instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", iq.dec_instr_o); end
        checks++; if (iq.iq_rd_ptr_o !== 3'd0) begin errors++; $display("FAIL rst_rdptr got=%0d exp=0", iq.iq_rd_ptr_o); end
        checks++; if (iq.protocol_err_o !== 1'b0) begin errors++; $display("FAIL rst_perr got=%b exp=0", iq.protocol_err_o); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        step();
        drive(1'b1, 32'h4, 1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 3'd1);
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", iq.dec_valid_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0093, 1'b1, 1'b0, 3'd2);
        checks++; if (iq.dec_valid_o !== 1'b1) begin errors++; $display("FAIL basic_v0 got=%b exp=1", iq.dec_valid_o); end
        checks++; if (iq.dec_pc_o !== 32'h0) begin errors++; $display("FAIL basic_pc0 got=%h exp=0", iq.dec_pc_o); end
        checks++; if (iq.dec_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL basic_i0 got=%h exp=00000013", iq.dec_instr_o); end
        checks++; if (iq.iq_rd_ptr_o !== 3'd0) begin errors++; $display("FAIL basic_rd0 got=%0d exp=0", iq.iq_rd_ptr_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd2);
        checks++; if (iq.dec_valid_o !== 1'b1) begin errors++; $display("FAIL basic_v1 got=%b exp=1", iq.dec_valid_o); end
        checks++; if (iq.dec_pc_o !== 32'h4) begin errors++; $display("FAIL basic_pc1 got=%h exp=4", iq.dec_pc_o); end
        checks++; if (iq.dec_instr_o !== 32'h0010_0093) begin errors++; $display("FAIL basic_i1 got=%h exp=00100093", iq.dec_instr_o); end
        checks++; if (iq.iq_rd_ptr_o !== 3'd1) begin errors++; $display("FAIL basic_rd1 got=%0d exp=1", iq.iq_rd_ptr_o); end
        step();
        step();
        checks++; if (iq.iq_rd_ptr_o !== 3'd2) begin errors++; $display("FAIL basic_rd2 got=%0d exp=2", iq.iq_rd_ptr_o); end
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", iq.dec_valid_o); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, 32'(32'h10 + 4 * k), k < 4, k > 0, 32'(32'hA0 + k - 1), 1'b0, 1'b0, 3'(k));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd4);
        step();
        checks++; if (iq.iq_rd_ptr_o !== 3'd0) begin errors++; $display("FAIL wrap_hold got=%0d exp=0", iq.iq_rd_ptr_o); end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd4);
            checks++; if (iq.dec_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_v%0d got=%b exp=1", j, iq.dec_valid_o); end
            checks++; if (iq.dec_pc_o !== 32'(32'h10 + 4 * j)) begin errors++; $display("FAIL wrap_pc%0d got=%h exp=%h", j, iq.dec_pc_o, 32'(32'h10 + 4 * j)); end
            checks++; if (iq.dec_instr_o !== 32'(32'hA0 + j)) begin errors++; $display("FAIL wrap_i%0d got=%h exp=%h", j, iq.dec_instr_o, 32'(32'hA0 + j)); end
            checks++; if (iq.iq_rd_ptr_o !== 3'(j)) begin errors++; $display("FAIL wrap_rd%0d got=%0d exp=%0d", j, iq.iq_rd_ptr_o, j); end
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd4);
        checks++; if (iq.iq_rd_ptr_o !== 3'b100) begin errors++; $display("FAIL wrap_rd4 got=%b exp=100", iq.iq_rd_ptr_o); end
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b exp=0", iq.dec_valid_o); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 32'h24, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd1);
        step();
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3'd2);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 3'd3);
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop1 got=%b exp=0", iq.dec_valid_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 3'd3);
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop2 got=%b exp=0", iq.dec_valid_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd3);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd3);
        checks++; if (iq.dec_valid_o !== 1'b1) begin errors++; $display("FAIL flush_v got=%b exp=1", iq.dec_valid_o); end
        checks++; if (iq.dec_pc_o !== 32'h100) begin errors++; $display("FAIL flush_pc got=%h exp=100", iq.dec_pc_o); end
        checks++; if (iq.dec_instr_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_i got=%h exp=deadbeef", iq.dec_instr_o); end
        checks++; if (iq.iq_rd_ptr_o !== 3'd2) begin errors++; $display("FAIL flush_rd got=%0d exp=2", iq.iq_rd_ptr_o); end
        iq.dec_ready_i = 1'b1;
        step();
        checks++; if (iq.iq_rd_ptr_o !== 3'd3) begin errors++; $display("FAIL flush_pop got=%0d exp=3", iq.iq_rd_ptr_o); end
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_BAD0, 1'b0, 1'b1, 3'd2);
        step();
        drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h0000_BAD1, 1'b0, 1'b0, 3'd2);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_0001, 1'b0, 1'b0, 3'd3);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd3);
        checks++; if (iq.dec_valid_o !== 1'b1) begin errors++; $display("FAIL frv_v got=%b exp=1", iq.dec_valid_o); end
        checks++; if (iq.dec_instr_o !== 32'h5555_0001) begin errors++; $display("FAIL frv_i got=%h exp=55550001", iq.dec_instr_o); end
        checks++; if (iq.dec_pc_o !== 32'h200) begin errors++; $display("FAIL frv_pc got=%h exp=200", iq.dec_pc_o); end
    endtask

    task automatic test_flush_pop();
        do_reset();
        drive(1'b1, 32'h60, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 3'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd1);
        checks++; if (iq.dec_valid_o !== 1'b1) begin errors++; $display("FAIL fpop_pre got=%b exp=1", iq.dec_valid_o); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd1);
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL fpop_mask got=%b exp=0", iq.dec_valid_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd1);
        checks++; if (iq.iq_rd_ptr_o !== 3'd1) begin errors++; $display("FAIL fpop_rd got=%0d exp=1", iq.iq_rd_ptr_o); end
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL fpop_v got=%b exp=0", iq.dec_valid_o); end
    endtask

    task automatic test_protocol_err();
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_EEEE, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        checks++; if (iq.protocol_err_o !== 1'b1) begin errors++; $display("FAIL perr_set got=%b exp=1", iq.protocol_err_o); end
        checks++; if (iq.dec_valid_o !== 1'b0) begin errors++; $display("FAIL perr_nofill got=%b exp=0", iq.dec_valid_o); end
        checks++; if (iq.iq_rd_ptr_o !== 3'd0) begin errors++; $display("FAIL perr_rd got=%0d exp=0", iq.iq_rd_ptr_o); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 3'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd1);
        checks++; if (iq.dec_instr_o !== 32'h99 || iq.dec_valid_o !== 1'b1) begin errors++; $display("FAIL perr_after got=%h/%b exp=00000099/1", iq.dec_instr_o, iq.dec_valid_o); end
        checks++; if (iq.protocol_err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", iq.protocol_err_o); end
        do_reset();
        checks++; if (iq.protocol_err_o !== 1'b0) begin errors++; $display("FAIL perr_clr got=%b exp=0", iq.protocol_err_o); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_basic();
        test_fill_wrap();
        test_flush();
        test_flush_rvalid();
        test_flush_pop();
        test_protocol_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
